// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and
// the bit-period helper used to derive baud-counter limits.
package uart_pkg;

    // Line levels of the framing bits, shared with the transmitter.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

    // Clock cycles per serial bit, rounded up so a bit is never sampled early.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud - 1) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
// RESET_VALUE lets the chain come out of reset at the line's idle level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resolution of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments make both flops sample together,
            // so r_sync takes the old r_meta and the chain really is two deep.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, finds the start bit, samples
// data bits at mid-bit (LSB first), checks the stop bit and presents each
// word on a ready/valid output with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE     = 115200,
    parameter int CLK_FREQUENCY = 48000000,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_uart,
    input  logic                 rx_rdy,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_err,
    output logic                 rx_overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_TICK = BAUD_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 w_rxs;
    uart_rx_state_t       r_state,  w_state_next;
    logic [BAUD_W-1:0]    r_baud,   w_baud_next;
    logic [BIT_W-1:0]     r_bit,    w_bit_next;
    logic [DATA_BITS-1:0] r_shift,  w_shift_next;
    logic                 w_deliver;
    logic                 w_frame_err;

    sync_2ff #(
        .RESET_VALUE(STOP_BIT)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_uart),
        .o_q   (w_rxs)
    );

    // Receiver state, baud/bit counters and the data shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    // Next-state decode: start qualification, mid-bit sampling, stop check.
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_baud_next  = r_baud + BAUD_W'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_deliver    = 1'b0;
        w_frame_err  = 1'b0;

        case (r_state)
            RX_IDLE: begin
                w_baud_next = '0;
                if (w_rxs == START_BIT) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_baud == HALF_TICK) begin
                    w_baud_next = '0;
                    if (w_rxs == START_BIT) begin
                        w_bit_next   = '0;
                        w_state_next = RX_DATA;
                    end else begin
                        w_state_next = RX_IDLE;   // glitch, not a real start
                    end
                end
            end
            RX_DATA: begin
                if (r_baud == LAST_TICK) begin
                    w_baud_next  = '0;
                    w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
                    w_bit_next   = r_bit + BIT_W'(1);
                    if (r_bit == LAST_BIT) begin
                        w_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_baud == LAST_TICK) begin
                    w_baud_next = '0;
                    if (w_rxs == STOP_BIT) begin
                        w_deliver    = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns high so a stuck-low line
                // cannot be decoded as a stream of frames.
                w_baud_next = '0;
                if (w_rxs == STOP_BIT) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // Output holding register with ready/valid handshake and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_err     <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_err     <= w_frame_err;
            rx_overrun <= 1'b0;
            if (w_deliver) begin
                if (!rx_valid || rx_rdy) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;   // held word wins, new one dropped
                end
            end else if (rx_valid && rx_rdy) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (417 clks/bit).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB     = 417;                    // ceil(48e6/115200)
    localparam int LATENCY = 2 + 208 + 9 * 417 + 1;  // 3964
    localparam int FRAME   = 10 * CPB;               // 4170

    logic       clk;
    logic       reset;
    logic       rx_uart;
    logic       rx_rdy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_overrun;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx_uart    (rx_uart),
        .rx_rdy     (rx_rdy),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_overrun (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records each rising edge of rx_valid and counts the
    // cycles that rx_err / rx_overrun are high.
    int         rise_cnt = 0;
    int         err_cyc  = 0;
    int         ovr_cyc  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] rise_data [64];
    int         rise_cyc  [64];

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            if (rise_cnt < 64) begin
                rise_data[rise_cnt] = rx_data;
                rise_cyc[rise_cnt]  = cyc;
            end
            rise_cnt = rise_cnt + 1;
        end
        if (rx_err)     err_cyc = err_cyc + 1;
        if (rx_overrun) ovr_cyc = ovr_cyc + 1;
        prev_valid = rx_valid;
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared = n_compared + 1;
        if (act !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_compared = n_compared + 1;
        if (act < lo || act > hi) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line left at the
    // stop-bit level, so consecutive calls produce back-to-back frames.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int t_fall);
        rx_uart = 1'b0;
        t_fall  = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_uart = data[i];
            idle(CPB);
        end
        rx_uart = stop_bit;
        idle(CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rdy;
        int         exp_rises;
        logic [7:0] exp_data;
        int         exp_err;
        int         exp_ovr;
        logic       exp_valid_end;
    } vec_t;

    vec_t vecs [6];

    int r0, e0, o0, t0, t1;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 0, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 1, 8'h5A, 0, 0, 1'b1};  // held, not taken
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 0, 0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 0, 0, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b1, 0, 8'h80, 1, 0, 1'b0};  // bad stop: data kept
        vecs[5] = '{8'hE7, 1'b1, 1'b1, 1, 8'hE7, 0, 0, 1'b0};

        reset   = 1'b1;
        rx_uart = 1'b1;
        rx_rdy  = 1'b0;
        idle(3);
        check("reset_valid",   32'(rx_valid),   32'd0);
        check("reset_data",    32'(rx_data),    32'd0);
        check("reset_err",     32'(rx_err),     32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        reset = 1'b0;
        idle(20);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
            rx_rdy = vecs[i].rdy;
            send_frame(vecs[i].data, vecs[i].stop, t0);
            rx_uart = 1'b1;
            idle(50);
            check($sformatf("vec%0d_rises", i),   32'(rise_cnt - r0),          32'(vecs[i].exp_rises));
            check($sformatf("vec%0d_data", i),    32'(rx_data),                32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),     32'(err_cyc - e0),           32'(vecs[i].exp_err));
            check($sformatf("vec%0d_overrun", i), 32'(ovr_cyc - o0),           32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_valid", i),   32'(rx_valid),               32'(vecs[i].exp_valid_end));
            if (i == 0 && r0 < 64)
                check_range("latency", rise_cyc[r0] - t0, LATENCY - 1, LATENCY + 1);
        end

        // Overrun: two frames with the consumer stalled.
        rx_rdy = 1'b0;
        r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
        send_frame(8'h3C, 1'b1, t0);
        send_frame(8'hC3, 1'b1, t1);
        idle(50);
        check("ovr_rises",   32'(rise_cnt - r0), 32'd1);
        check("ovr_valid",   32'(rx_valid),      32'd1);
        check("ovr_data",    32'(rx_data),       32'h3C);
        check("ovr_pulses",  32'(ovr_cyc - o0),  32'd1);
        check("ovr_err",     32'(err_cyc - e0),  32'd0);
        rx_rdy = 1'b1;
        idle(1);
        check("ovr_consumed_valid", 32'(rx_valid), 32'd0);
        check("ovr_consumed_data",  32'(rx_data),  32'h3C);

        // Short low glitch on the line: no frame, then normal reception.
        r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
        rx_uart = 1'b0;
        idle(100);
        rx_uart = 1'b1;
        idle(300);
        check("glitch_rises",   32'(rise_cnt - r0), 32'd0);
        check("glitch_err",     32'(err_cyc - e0),  32'd0);
        check("glitch_overrun", 32'(ovr_cyc - o0),  32'd0);
        send_frame(8'h96, 1'b1, t0);
        idle(50);
        check("post_glitch_rises", 32'(rise_cnt - r0), 32'd1);
        check("post_glitch_data",  32'(rx_data),       32'h96);

        // Framing error followed by a long break, then a good frame.
        r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
        send_frame(8'h55, 1'b0, t0);
        idle(5000);
        rx_uart = 1'b1;
        idle(100);
        check("break_err",     32'(err_cyc - e0),  32'd1);
        check("break_rises",   32'(rise_cnt - r0), 32'd0);
        send_frame(8'h0F, 1'b1, t0);
        idle(50);
        check("break_rx_rises", 32'(rise_cnt - r0), 32'd1);
        check("break_rx_data",  32'(rx_data),       32'h0F);
        check("break_overrun",  32'(ovr_cyc - o0),  32'd0);

        // Reset in the middle of data bit 4 of 0xFF.
        r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
        rx_uart = 1'b0;
        idle(CPB);
        rx_uart = 1'b1;
        idle(4 * CPB + 200);
        reset = 1'b1;
        idle(1);
        check("midrst_valid",   32'(rx_valid),   32'd0);
        check("midrst_data",    32'(rx_data),    32'd0);
        check("midrst_err",     32'(rx_err),     32'd0);
        check("midrst_overrun", 32'(rx_overrun), 32'd0);
        idle(10);
        reset = 1'b0;
        idle(500);
        check("midrst_no_word", 32'(rise_cnt - r0), 32'd0);
        send_frame(8'h81, 1'b1, t0);
        idle(50);
        check("midrst_rx_rises", 32'(rise_cnt - r0), 32'd1);
        check("midrst_rx_data",  32'(rx_data),       32'h81);
        check("midrst_err_cnt",  32'(err_cyc - e0),  32'd0);

        // Back-to-back frames with the consumer always ready.
        rx_rdy = 1'b1;
        r0 = rise_cnt; e0 = err_cyc; o0 = ovr_cyc;
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        idle(50);
        check("b2b_rises", 32'(rise_cnt - r0), 32'd2);
        if (r0 + 1 < 64) begin
            check("b2b_first",  32'(rise_data[r0]),     32'h00);
            check("b2b_second", 32'(rise_data[r0 + 1]), 32'hFF);
            check_range("b2b_spacing", rise_cyc[r0 + 1] - rise_cyc[r0], FRAME - 1, FRAME + 1);
        end
        check("b2b_err",     32'(err_cyc - e0), 32'd0);
        check("b2b_overrun", 32'(ovr_cyc - o0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
